rule_packer_256_512: RTL and testbench



---
 rtl/rule_packer_256_512.sv | 130 +++++++++++++
 tb/tb_rule_packer_256_512.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rule_packer_256_512.sv
// Packs 256-bit rule beats into 512-bit rule words and closes each packet with an all-zero marker word.
// Optional build macro RULE_PACKER_DROP_ZERO_EN: discard all-zero rule beats instead of packing them.
module rule_packer_256_512 (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] in_rule_data,
  input  logic         in_rule_valid,
  input  logic         in_rule_sop,
  input  logic         in_rule_eop,
  input  logic [4:0]   in_rule_empty,
  output logic         in_rule_ready,
  output logic [511:0] out_rule_data,
  output logic         out_rule_valid,
  output logic         out_rule_sop,
  output logic         out_rule_eop,
  output logic [5:0]   out_rule_empty,
  input  logic         out_rule_ready,
  output logic [31:0]  rule_cnt
);

  localparam int unsigned IN_W  = 256;
  localparam int unsigned OUT_W = 512;

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FLUSH} state_t;

  state_t             r_state, w_state_n;
  logic [IN_W-1:0]    r_pend;
  logic               r_msop;
  logic               w_can_load, w_accept, w_drop;
  logic               w_load, w_ld_sop, w_ld_eop;
  logic [OUT_W-1:0]   w_ld_data;
  logic               w_pend_we, w_msop_we, w_cnt_inc;
  logic               w_unused;

  // Beat width is fixed, so the input empty field carries no information.
  assign w_unused       = ^in_rule_empty;
  assign out_rule_empty = 6'd0;

  assign w_can_load    = !out_rule_valid || out_rule_ready;
  assign in_rule_ready = !rst && (r_state != S_FLUSH) && w_can_load;
  assign w_accept      = in_rule_valid && in_rule_ready;

`ifdef RULE_PACKER_DROP_ZERO_EN
  assign w_drop = !in_rule_eop && (in_rule_data == IN_W'(0));
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_n;
  end

  // Next state and output-register load selection
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_sop  = 1'b0;
    w_ld_eop  = 1'b0;
    w_pend_we = 1'b0;
    w_msop_we = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          if (in_rule_eop) begin
            w_load   = 1'b1;
            w_ld_eop = 1'b1;
            w_ld_sop = in_rule_sop;
          end else if (!w_drop) begin
            w_pend_we = 1'b1;
            w_cnt_inc = 1'b1;
            w_state_n = S_HALF;
          end
        end
      end
      S_HALF: begin
        if (w_accept) begin
          if (in_rule_eop) begin
            w_load    = 1'b1;
            w_ld_data = {IN_W'(0), r_pend};
            w_msop_we = 1'b1;
            w_state_n = S_FLUSH;
          end else if (!w_drop) begin
            w_load    = 1'b1;
            w_ld_data = {in_rule_data, r_pend};
            w_cnt_inc = 1'b1;
            w_state_n = S_EMPTY;
          end
        end
      end
      S_FLUSH: begin
        if (w_can_load) begin
          w_load    = 1'b1;
          w_ld_eop  = 1'b1;
          w_ld_sop  = r_msop;
          w_state_n = S_EMPTY;
        end
      end
      default: w_state_n = S_EMPTY;
    endcase
  end

  // Datapath registers and the single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend         <= '0;
      r_msop         <= 1'b0;
      rule_cnt       <= '0;
      out_rule_valid <= 1'b0;
      out_rule_data  <= '0;
      out_rule_sop   <= 1'b0;
      out_rule_eop   <= 1'b0;
    end else begin
      if (w_pend_we) r_pend   <= in_rule_data;
      if (w_msop_we) r_msop   <= in_rule_sop;
      if (w_cnt_inc) rule_cnt <= rule_cnt + 32'd1;
      if (w_load) begin
        out_rule_valid <= 1'b1;
        out_rule_data  <= w_ld_data;
        out_rule_sop   <= w_ld_sop;
        out_rule_eop   <= w_ld_eop;
      end else if (out_rule_valid && out_rule_ready) begin
        out_rule_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rule_packer_256_512.sv
// Directed, table-driven bench for rule_packer_256_512; one row per clock cycle.
module tb_rule_packer_256_512;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_rule_data;
  logic         in_rule_valid, in_rule_sop, in_rule_eop;
  logic [4:0]   in_rule_empty;
  logic         in_rule_ready;
  logic [511:0] out_rule_data;
  logic         out_rule_valid, out_rule_sop, out_rule_eop;
  logic [5:0]   out_rule_empty;
  logic         out_rule_ready;
  logic [31:0]  rule_cnt;

  rule_packer_256_512 dut (
    .clk(clk), .rst(rst),
    .in_rule_data(in_rule_data), .in_rule_valid(in_rule_valid),
    .in_rule_sop(in_rule_sop), .in_rule_eop(in_rule_eop),
    .in_rule_empty(in_rule_empty), .in_rule_ready(in_rule_ready),
    .out_rule_data(out_rule_data), .out_rule_valid(out_rule_valid),
    .out_rule_sop(out_rule_sop), .out_rule_eop(out_rule_eop),
    .out_rule_empty(out_rule_empty), .out_rule_ready(out_rule_ready),
    .rule_cnt(rule_cnt)
  );

  always #5 clk = ~clk;

`ifdef RULE_PACKER_DROP_ZERO_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  // Inputs driven this cycle; expectations observed before this cycle's clock edge.
  typedef struct {
    logic         rst, vld;
    logic [255:0] d;
    logic         sop, eop, ordy;
    logic         irdy, ov;
    logic [511:0] od;
    logic         osop, oeop;
    logic [31:0]  cnt;
    logic         full;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [255:0] A = 256'h1, B = 256'h2, C = 256'h3, D = 256'h4, E = 256'h5;
  localparam logic [255:0] Z = 256'h0, G = 256'hdead_beef;

  function automatic vec_t row(logic r, logic v, logic [255:0] d, logic s, logic e, logic ordy,
                               logic irdy, logic ov, logic [511:0] od, logic os, logic oe,
                               int unsigned cnt, logic full);
    vec_t x;
    x.rst = r; x.vld = v; x.d = d; x.sop = s; x.eop = e; x.ordy = ordy;
    x.irdy = irdy; x.ov = ov; x.od = od; x.osop = os; x.oeop = oe;
    x.cnt = 32'(cnt); x.full = full;
    return x;
  endfunction

  task automatic chk(string name, int idx, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Idle cycle with out_rule_ready high
  function automatic vec_t idle(logic irdy, logic ov, logic [511:0] od, logic os, logic oe,
                                int unsigned cnt);
    return row(0, 0, Z, 0, 0, 1, irdy, ov, od, os, oe, cnt, 0);
  endfunction

  initial begin
    int unsigned cb;
    // Pair then eop: {B,A} then marker sop=0
    tbl.push_back(row(0, 1, A, 0, 0, 1, 1, 0, '0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, B, 0, 0, 1, 1, 0, '0, 0, 0, 1, 0));
    tbl.push_back(row(0, 1, G, 0, 1, 1, 1, 1, {B, A}, 0, 0, 2, 0));
    tbl.push_back(idle(1, 1, '0, 0, 1, 2));
    tbl.push_back(idle(1, 0, '0, 0, 0, 2));
    // Odd beat: {B,A}, {0,C}, one FLUSH stall, marker sop=1
    tbl.push_back(row(0, 1, A, 0, 0, 1, 1, 0, '0, 0, 0, 2, 0));
    tbl.push_back(row(0, 1, B, 0, 0, 1, 1, 0, '0, 0, 0, 3, 0));
    tbl.push_back(row(0, 1, C, 0, 0, 1, 1, 1, {B, A}, 0, 0, 4, 0));
    tbl.push_back(row(0, 1, G, 1, 1, 1, 1, 0, '0, 0, 0, 5, 0));
    tbl.push_back(row(0, 1, D, 0, 0, 1, 0, 1, {Z, C}, 0, 0, 5, 0));
    tbl.push_back(idle(1, 1, '0, 1, 1, 5));
    tbl.push_back(idle(1, 0, '0, 0, 0, 5));
    // A, zero beat, B, eop
    tbl.push_back(row(0, 1, A, 0, 0, 1, 1, 0, '0, 0, 0, 5, 0));
    if (DROP) begin
      tbl.push_back(row(0, 1, Z, 0, 0, 1, 1, 0, '0, 0, 0, 6, 0));
      tbl.push_back(row(0, 1, B, 0, 0, 1, 1, 0, '0, 0, 0, 6, 0));
      tbl.push_back(row(0, 1, G, 0, 1, 1, 1, 1, {B, A}, 0, 0, 7, 0));
      tbl.push_back(idle(1, 1, '0, 0, 1, 7));
      tbl.push_back(idle(1, 0, '0, 0, 0, 7));
      cb = 7;
    end else begin
      tbl.push_back(row(0, 1, Z, 0, 0, 1, 1, 0, '0, 0, 0, 6, 0));
      tbl.push_back(row(0, 1, B, 0, 0, 1, 1, 1, {Z, A}, 0, 0, 7, 0));
      tbl.push_back(row(0, 1, G, 0, 1, 1, 1, 0, '0, 0, 0, 8, 0));
      tbl.push_back(idle(0, 1, {Z, B}, 0, 0, 8));
      tbl.push_back(idle(1, 1, '0, 0, 1, 8));
      tbl.push_back(idle(1, 0, '0, 0, 0, 8));
      cb = 8;
    end
    // Lone eop in EMPTY: single marker, sop=1
    tbl.push_back(row(0, 1, G, 1, 1, 1, 1, 0, '0, 0, 0, cb, 0));
    tbl.push_back(idle(1, 1, '0, 1, 1, cb));
    tbl.push_back(idle(1, 0, '0, 0, 0, cb));
    // Backpressure: {B,A} held 5 cycles while C waits, then {D,C}
    tbl.push_back(row(0, 1, A, 0, 0, 1, 1, 0, '0, 0, 0, cb, 0));
    tbl.push_back(row(0, 1, B, 0, 0, 1, 1, 0, '0, 0, 0, cb + 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(row(0, 1, C, 0, 0, 0, 0, 1, {B, A}, 0, 0, cb + 2, 1));
    tbl.push_back(row(0, 1, C, 0, 0, 1, 1, 1, {B, A}, 0, 0, cb + 2, 1));
    tbl.push_back(row(0, 1, D, 0, 0, 1, 1, 0, '0, 0, 0, cb + 3, 0));
    tbl.push_back(idle(1, 1, {D, C}, 0, 0, cb + 4));
    // Reset while HALF holds A; A must not reappear
    tbl.push_back(row(0, 1, A, 0, 0, 1, 1, 0, '0, 0, 0, cb + 4, 0));
    tbl.push_back(row(1, 1, B, 0, 0, 1, 0, 0, '0, 0, 0, cb + 5, 0));
    tbl.push_back(row(0, 0, Z, 0, 0, 1, 1, 0, '0, 0, 0, 0, 1));
    tbl.push_back(row(0, 1, D, 0, 0, 1, 1, 0, '0, 0, 0, 0, 0));
    tbl.push_back(row(0, 1, E, 0, 0, 1, 1, 0, '0, 0, 0, 1, 0));
    tbl.push_back(row(0, 1, G, 0, 1, 1, 1, 1, {E, D}, 0, 0, 2, 0));
    tbl.push_back(idle(1, 1, '0, 0, 1, 2));
    tbl.push_back(idle(1, 0, '0, 0, 0, 2));

    rst = 1'b1; in_rule_valid = 1'b0; in_rule_data = '0; in_rule_sop = 1'b0;
    in_rule_eop = 1'b0; in_rule_empty = 5'h1f; out_rule_ready = 1'b1;
    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; in_rule_valid = tbl[i].vld; in_rule_data = tbl[i].d;
      in_rule_sop = tbl[i].sop; in_rule_eop = tbl[i].eop; out_rule_ready = tbl[i].ordy;
      #1;
      chk("in_rule_ready", i, 512'(in_rule_ready), 512'(tbl[i].irdy));
      chk("out_rule_valid", i, 512'(out_rule_valid), 512'(tbl[i].ov));
      chk("rule_cnt", i, 512'(rule_cnt), 512'(tbl[i].cnt));
      chk("out_rule_empty", i, 512'(out_rule_empty), 512'(0));
      if (tbl[i].ov || tbl[i].full) begin
        chk("out_rule_data", i, out_rule_data, tbl[i].od);
        chk("out_rule_sop", i, 512'(out_rule_sop), 512'(tbl[i].osop));
        chk("out_rule_eop", i, 512'(out_rule_eop), 512'(tbl[i].oeop));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
